// File: rtl/axil_hash_ctrl.sv
// AXI4-Lite front-end for iterative hash cores: message block buffer, command
// sequencing towards the core, digest shadow and a maskable W1C interrupt.

module axil_hash_word (
  input  logic        gclk,
  input  logic        grst_n,
  input  logic        we,
  input  logic [3:0]  strb,
  input  logic [31:0] wdata,
  output logic [31:0] q
);
  for (genvar b = 0; b < 4; b++) begin : g_byte
    always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n)             q[8*b +: 8] <= '0;
      else if (we && strb[b])  q[8*b +: 8] <= wdata[8*b +: 8];
    end
  end
endmodule

module axil_hash_ctrl #(
  parameter int          ADDR_WIDTH   = 8,
  parameter int          BLOCK_WORDS  = 16,
  parameter int          DIGEST_WORDS = 8,
  parameter logic [31:0] VERSION      = 32'h0002_0100
) (
  input  logic                      s_axi_clk,
  input  logic                      s_axi_rst_n,
  input  logic [31:0]               s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [31:0]               s_axi_wdata,
  input  logic [3:0]                s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [31:0]               s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [31:0]               s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic                      core_init,
  output logic                      core_next,
  output logic [32*BLOCK_WORDS-1:0] core_block,
  input  logic                      core_ready,
  input  logic [32*DIGEST_WORDS-1:0] core_digest,
  input  logic                      core_digest_valid,
  output logic                      interrupt
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI} state_t;

  typedef struct packed {
    logic       ctrl;
    logic       stat;
    logic       ver;
    logic       blk;
    logic       dig;
    logic [3:0] idx;
  } dec_t;

  // Address bits [1:0] are ignored; anything above the decoded window must be zero.
  function automatic dec_t dec(input logic [ADDR_WIDTH-1:0] a);
    dec_t d;
    d     = '0;
    d.idx = a[5:2];
    if ((a >> 8) == '0) begin
      case (a[7:6])
        2'b00: begin
          d.ctrl = (a[5:2] == 4'd0);
          d.stat = (a[5:2] == 4'd1);
          d.ver  = (a[5:2] == 4'd2);
        end
        2'b01:   d.blk = (int'(a[5:2]) < BLOCK_WORDS);
        2'b10:   d.dig = (int'(a[5:2]) < DIGEST_WORDS);
        default: ;
      endcase
    end
    return d;
  endfunction

  state_t state_q, state_d;
  logic   cmd_init_q;
  logic   irq_en_q, irq_pend_q, dig_vld_q;
  logic   capture;
  logic   busy;

  logic [BLOCK_WORDS-1:0][31:0]  blk_q;
  logic [DIGEST_WORDS-1:0][31:0] dig_q;

  logic unused_addr;
  assign unused_addr = ^{s_axi_awaddr[31:ADDR_WIDTH], s_axi_araddr[31:ADDR_WIDTH]};

  assign busy      = (state_q != IDLE);
  assign interrupt = irq_pend_q & irq_en_q;

  // ---------------- write channel ----------------
  dec_t wd;
  logic wr_fire, ctrl_cmd, wr_err, blk_we, start, irq_clr, irq_en_we;

  assign wd        = dec(s_axi_awaddr[ADDR_WIDTH-1:0]);
  assign wr_fire   = s_axi_awready & s_axi_awvalid & s_axi_wvalid;
  assign ctrl_cmd  = wd.ctrl & s_axi_wstrb[0] & (s_axi_wdata[0] | s_axi_wdata[1]);
  assign wr_err    = !(wd.ctrl | wd.stat | wd.blk) | (wd.blk & busy) | (ctrl_cmd & busy);
  assign blk_we    = wr_fire & wd.blk & !busy;
  assign start     = wr_fire & ctrl_cmd & !busy;
  assign irq_en_we = wr_fire & wd.ctrl & s_axi_wstrb[0];
  assign irq_clr   = wr_fire & wd.stat & s_axi_wstrb[0] & s_axi_wdata[2];

  // Ready pulses for one cycle and re-arms only after the response has drained.
  always_ff @(posedge s_axi_clk or negedge s_axi_rst_n) begin
    if (!s_axi_rst_n) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
    end else begin
      s_axi_awready <= s_axi_awvalid & s_axi_wvalid & !s_axi_bvalid & !s_axi_awready;
      s_axi_wready  <= s_axi_awvalid & s_axi_wvalid & !s_axi_bvalid & !s_axi_awready;
      if (wr_fire) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < BLOCK_WORDS; i++) begin : g_lane
    axil_hash_word u_word (
      .gclk   (s_axi_clk),
      .grst_n (s_axi_rst_n),
      .we     (blk_we && (wd.idx == 4'(i))),
      .strb   (s_axi_wstrb),
      .wdata  (s_axi_wdata),
      .q      (blk_q[i])
    );
    assign core_block[32*(BLOCK_WORDS-i)-1 -: 32] = blk_q[i];
  end

  // ---------------- read channel ----------------
  dec_t        rd;
  logic        rd_fire, rd_err;
  logic [31:0] rd_data;

  assign rd      = dec(s_axi_araddr[ADDR_WIDTH-1:0]);
  assign rd_fire = s_axi_arready & s_axi_arvalid;

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (rd.ctrl)      rd_data = {29'b0, irq_en_q, 2'b0};
    else if (rd.stat) rd_data = {28'b0, busy, irq_pend_q, dig_vld_q, core_ready};
    else if (rd.ver)  rd_data = VERSION;
    else if (rd.blk) begin
      for (int i = 0; i < BLOCK_WORDS; i++)
        if (int'(rd.idx) == i) rd_data = blk_q[i];
    end else if (rd.dig) begin
      for (int j = 0; j < DIGEST_WORDS; j++)
        if (int'(rd.idx) == j) rd_data = dig_q[j];
    end else rd_err = 1'b1;
  end

  always_ff @(posedge s_axi_clk or negedge s_axi_rst_n) begin
    if (!s_axi_rst_n) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      s_axi_arready <= s_axi_arvalid & !s_axi_rvalid & !s_axi_arready;
      if (rd_fire) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_data;
        s_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  // ---------------- command FSM ----------------
  always_ff @(posedge s_axi_clk or negedge s_axi_rst_n) begin
    if (!s_axi_rst_n) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    core_init = 1'b0;
    core_next = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE: begin
        core_init = cmd_init_q;
        core_next = !cmd_init_q;
        state_d   = WAIT_LO;
      end
      WAIT_LO: if (!core_ready) state_d = WAIT_HI;
      WAIT_HI: if (core_ready && core_digest_valid) begin
        capture = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Digest word 0 sits in the MS bits of the core result, mirroring core_block.
  always_ff @(posedge s_axi_clk or negedge s_axi_rst_n) begin
    if (!s_axi_rst_n) begin
      cmd_init_q <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
      dig_vld_q  <= 1'b0;
      dig_q      <= '0;
    end else begin
      if (start)     cmd_init_q <= s_axi_wdata[0];
      if (irq_en_we) irq_en_q   <= s_axi_wdata[2];
      if (capture)      irq_pend_q <= 1'b1;
      else if (irq_clr) irq_pend_q <= 1'b0;
      if (state_q == ISSUE) dig_vld_q <= 1'b0;
      else if (capture)     dig_vld_q <= 1'b1;
      if (capture)
        for (int j = 0; j < DIGEST_WORDS; j++)
          dig_q[j] <= core_digest[32*(DIGEST_WORDS-j)-1 -: 32];
    end
  end

endmodule

// File: tb/tb_axil_hash_ctrl.sv
// Directed bench for axil_hash_ctrl: register-map vector table plus hand-written
// sequences for a full hash command, busy rejection, read back-pressure and reset.

module tb_axil_hash_ctrl;

  localparam logic [31:0] VER = 32'h0002_0100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  awaddr, wdata, araddr;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic [3:0]   wstrb;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic         core_init, core_next, core_ready, core_digest_valid, interrupt;
  logic [511:0] core_block;
  logic [255:0] core_digest;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int init_cnt = 0;
  int next_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_init) init_cnt <= init_cnt + 1;
    if (core_next) next_cnt <= next_cnt + 1;
  end

  axil_hash_ctrl dut (
    .s_axi_clk(clk), .s_axi_rst_n(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .core_init(core_init), .core_next(core_next), .core_block(core_block),
    .core_ready(core_ready), .core_digest(core_digest),
    .core_digest_valid(core_digest_valid), .interrupt(interrupt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) chk("aw_timeout", 32'(awready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bvalid) chk("b_timeout", 32'(bvalid), 32'd1);
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) chk("ar_timeout", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    if (!rvalid) chk("r_timeout", 32'(rvalid), 32'd1);
    d = rdata; resp = rresp;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[18];

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          t0, n, snap;
    bit          ok;

    vecs[0]  = '{1'b0, 32'h08,   32'h0,         4'h0, VER,           2'b00};
    vecs[1]  = '{1'b0, 32'h04,   32'h0,         4'h0, 32'h1,         2'b00};
    vecs[2]  = '{1'b0, 32'h00,   32'h0,         4'h0, 32'h0,         2'b00};
    vecs[3]  = '{1'b0, 32'h84,   32'h0,         4'h0, 32'h0,         2'b00};
    vecs[4]  = '{1'b1, 32'h40,   32'hAABBCCDD,  4'h5, 32'h0,         2'b00};
    vecs[5]  = '{1'b0, 32'h40,   32'h0,         4'h0, 32'h00BB00DD,  2'b00};
    vecs[6]  = '{1'b1, 32'h7C,   32'h12345678,  4'hF, 32'h0,         2'b00};
    vecs[7]  = '{1'b0, 32'h7C,   32'h0,         4'h0, 32'h12345678,  2'b00};
    vecs[8]  = '{1'b1, 32'h1044, 32'hDEADBEEF,  4'hF, 32'h0,         2'b00};
    vecs[9]  = '{1'b0, 32'h44,   32'h0,         4'h0, 32'hDEADBEEF,  2'b00};
    vecs[10] = '{1'b1, 32'h08,   32'h1,         4'hF, 32'h0,         2'b10};
    vecs[11] = '{1'b1, 32'h80,   32'h1,         4'hF, 32'h0,         2'b10};
    vecs[12] = '{1'b0, 32'hC0,   32'h0,         4'h0, 32'h0,         2'b10};
    vecs[13] = '{1'b0, 32'hA0,   32'h0,         4'h0, 32'h0,         2'b10};
    vecs[14] = '{1'b1, 32'h00,   32'h4,         4'hF, 32'h0,         2'b00};
    vecs[15] = '{1'b0, 32'h00,   32'h0,         4'h0, 32'h4,         2'b00};
    vecs[16] = '{1'b1, 32'h04,   32'hFFFFFFFB,  4'hF, 32'h0,         2'b00};
    vecs[17] = '{1'b0, 32'h04,   32'h0,         4'h0, 32'h1,         2'b00};

    rst_n = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; awvalid = 0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    core_ready = 1'b1; core_digest_valid = 1'b0; core_digest = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", 32'({awready, wready, bvalid, arready, rvalid, core_init, core_next, interrupt}), 32'h0);
    chk("reset_data", rdata | 32'({bresp, rresp}), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
        chk($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].exp_resp));
      end else begin
        axi_read(vecs[i].addr, d, r);
        chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
        chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].exp_resp));
      end
    end

    for (int i = 0; i < 16; i++) axi_write(32'h40 + 32'(4*i), 32'hB000_0000 + 32'(i), 4'hF, r);
    chk("block_w0", core_block[511:480], 32'hB000_0000);
    chk("block_w15", core_block[31:0], 32'hB000_000F);

    axi_write(32'h00, 32'h5, 4'hF, r);
    chk("init_bresp", 32'(r), 32'h0);
    @(negedge clk);
    core_ready = 1'b0;
    t0 = cyc;
    repeat (3) @(negedge clk);
    chk("init_pulse_cnt", 32'(init_cnt), 32'd1);

    axi_write(32'h44, 32'hFFFFFFFF, 4'hF, r);
    chk("busy_blk_bresp", 32'(r), 32'h2);
    axi_read(32'h44, d, r);
    chk("busy_blk_keep", d, 32'hB000_0001);
    axi_write(32'h00, 32'h2, 4'hF, r);
    chk("busy_next_bresp", 32'(r), 32'h2);
    axi_write(32'h00, 32'h4, 4'hF, r);
    chk("busy_irqen_bresp", 32'(r), 32'h0);
    axi_read(32'h04, d, r);
    chk("busy_status", d, 32'h8);
    while (cyc - t0 < 64) @(negedge clk);
    chk("no_core_next", 32'(next_cnt), 32'd0);

    for (int j = 0; j < 8; j++) core_digest[255-32*j -: 32] = 32'hD000_0000 + 32'(j);
    core_digest[255:224] = 32'h6A09E667;
    core_digest_valid = 1'b1;
    core_ready = 1'b1;
    n = 0;
    d = 32'h8;
    while (d[3] && n < 20) begin axi_read(32'h04, d, r); n++; end
    chk("done_status", d, 32'h7);
    chk("interrupt_set", 32'(interrupt), 32'd1);
    axi_read(32'h80, d, r);
    chk("digest_w0", d, 32'h6A09E667);
    axi_read(32'h9C, d, r);
    chk("digest_w7", d, 32'hD000_0007);
    axi_write(32'h04, 32'h4, 4'hF, r);
    chk("w1c_bresp", 32'(r), 32'h0);
    @(negedge clk);
    chk("interrupt_clr", 32'(interrupt), 32'd0);
    chk("init_total", 32'(init_cnt), 32'd1);

    // read response held under back-pressure
    @(negedge clk);
    araddr = 32'h08; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!(rvalid === 1'b1 && rdata === VER && rresp === 2'b00)) ok = 1'b0;
    end
    chk("rhold_stable", 32'(ok), 32'd1);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    @(negedge clk);
    chk("rhold_drain", 32'(rvalid), 32'd0);

    // reset while parked in WAIT_LO (core_ready kept high)
    axi_write(32'h00, 32'h1, 4'hF, r);
    repeat (3) @(negedge clk);
    axi_read(32'h04, d, r);
    chk("waitlo_status", d, 32'h9);
    @(negedge clk);
    araddr = 32'h08; arvalid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctl", 32'({awready, wready, bvalid, arready, rvalid, core_init, core_next, interrupt}), 32'h0);
    chk("midrst_data", rdata | 32'({bresp, rresp}), 32'h0);
    arvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    snap = init_cnt + next_cnt;
    repeat (5) @(negedge clk);
    chk("no_pulse_after_rst", 32'(init_cnt + next_cnt), 32'(snap));
    axi_read(32'h04, d, r);
    chk("post_rst_status", d, 32'h1);
    axi_read(32'h40, d, r);
    chk("post_rst_blk0", d, 32'h0);
    axi_read(32'h00, d, r);
    chk("post_rst_ctrl", d, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/axil_hash_ctrl.md
Name: axil_hash_ctrl

Overview:
- Parametrised AXI4-Lite slave front-end for iterative hash cores (SHA-256 class); next generation of the hash-core AXI wrapper.
- Owns the message block buffer, command sequencing, digest capture and a maskable W1C interrupt.
- Core-side port is generic (block width and digest width are parameters), so one front-end serves several hash cores.
- Sits between the SoC AXI4-Lite interconnect and a bare hash core.

Parameters:
- ADDR_WIDTH, 8, decoded low address bits; upper bits of the 32-bit address are ignored.
- BLOCK_WORDS, 16, 32-bit words per message block, 1..16.
- DIGEST_WORDS, 8, 32-bit words per digest, 1..16.
- VERSION, 32'h0002_0100, constant returned by the VERSION register.

Ports:
- s_axi_clk  in  1  clock.
- s_axi_rst_n  in  1  reset, asynchronous, active-low.
- s_axi_awaddr  in  32  write address.
- s_axi_awvalid/s_axi_awready  in/out  1  AW handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte strobes.
- s_axi_wvalid/s_axi_wready  in/out  1  W handshake.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid/s_axi_bready  out/in  1  B handshake.
- s_axi_araddr  in  32  read address.
- s_axi_arvalid/s_axi_arready  in/out  1  AR handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid/s_axi_rready  out/in  1  R handshake.
- core_init  out  1  one-cycle pulse: start the first block.
- core_next  out  1  one-cycle pulse: start a continuation block.
- core_block  out  32*BLOCK_WORDS  buffer contents; word 0 occupies the MS bits.
- core_ready  in  1  core idle.
- core_digest  in  32*DIGEST_WORDS  core result.
- core_digest_valid  in  1  level; core result is valid.
- interrupt  out  1  irq_pend AND irq_en.

Behaviour:
- Reset values (async, s_axi_rst_n low):
  - All AXI ready/valid outputs, core_init, core_next, interrupt: 0.
  - rdata, bresp, rresp: 0.
  - Block buffer, digest shadow, irq_en, irq_pend: 0.
  - Command FSM: IDLE.
- Register map (byte offsets):
  - 0x00 CTRL W: bit0 INIT, bit1 NEXT, bit2 IRQ_EN (stored). Reads return {29'b0, irq_en, 2'b0}.
  - 0x04 STATUS R: bit0 core_ready, bit1 digest_valid, bit2 irq_pend, bit3 busy. Writing 1 to bit2 clears irq_pend; all other STATUS bits ignore writes.
  - 0x08 VERSION R.
  - 0x40+4i, i<BLOCK_WORDS: block word i, RW.
  - 0x80+4j, j<DIGEST_WORDS: digest shadow word j, R.
  - Any other offset, or a word index at or beyond the parameter limit, is unmapped.
- Write channel:
  - awready and wready pulse together for 1 cycle, only when awvalid & wvalid & !bvalid.
  - Register update occurs on that same edge. Byte i is written only where wstrb[i]=1.
  - bvalid rises the next cycle and is held until bready.
  - bresp = OKAY (00), or SLVERR (10) with no state change when:
    - the offset is unmapped;
    - the target is VERSION or digest;
    - the target is a block word while busy;
    - CTRL is written with INIT or NEXT set while busy. IRQ_EN still updates in this case.
- Read channel:
  - arready pulses for 1 cycle when arvalid & !rvalid.
  - rdata/rresp are registered and rvalid rises the next cycle, held with stable data until rready.
  - Unmapped offset: rdata 0, rresp SLVERR.
  - Read and write may complete in the same cycle.
- Command FSM (busy = state != IDLE):
  - IDLE: a CTRL write with INIT or NEXT set moves to ISSUE. If both bits are set, INIT wins.
  - ISSUE: exactly one cycle of core_init or core_next. Clears the digest_valid shadow, then goes to WAIT_LO.
  - WAIT_LO: waits for core_ready=0, then goes to WAIT_HI. No timeout.
  - WAIT_HI: on core_ready=1 & core_digest_valid=1, captures core_digest into the shadow, sets digest_valid, then goes to IDLE.
- Interrupt:
  - irq_pend is set on the WAIT_HI→IDLE transition.
  - If a set and a W1C clear occur in the same cycle, set wins.
  - interrupt is combinational from registered bits; it is cleared by W1C or by irq_en=0.
- Reset mid-operation returns everything to reset values immediately; no core pulse is emitted after reset deassertion.

Test Plan:
- Reset, then read 0x08 → rdata 32'h0002_0100, rresp 00. Read 0x04 with core_ready=1 → 32'h1.
- Write 0x40 data 32'hAABBCCDD strb 4'b0101, over prior 0 → read-back 32'h00BB00DD, bresp 00.
- Fill 16 block words, write CTRL 32'h5 → core_init high exactly 1 cycle. Core drops ready for 64 cycles, then returns ready with digest word0=32'h6A09E667 → read 0x80 returns 32'h6A09E667, STATUS=32'h7, interrupt=1. Write 0x04 data 32'h4 → interrupt=0.
- While busy: write 0x44 → bresp 10 and word unchanged; write CTRL 32'h2 → bresp 10 and no core_next.
- Read 0xC0 and write 0x08 → SLVERR on both. Hold rready=0 for 5 cycles → rvalid and rdata stable throughout.
- Assert s_axi_rst_n=0 in WAIT_LO → all outputs 0 asynchronously; after release, STATUS busy=0 and block word0=0.
